seg_scan_scheduler: RTL and testbench
=====================================

Name: seg_scan_scheduler

Overview:
Time-multiplexing scan controller for the 4-digit seven-segment display. It sequences digit enables with anti-ghosting blanking. It also arbitrates the display between two 16-bit BCD pages: page0 is the default clock mm:ss, and page1 is an alert page such as a TLC phase countdown requested by the controller. Sits between the clock/TLC datapath and the HEX/anode pins.

Parameters:
SCAN_DIV, 4096, clk cycles per digit slot (>= BLANK_CYC+1)
BLANK_CYC, 64, cycles at start of each slot with all digits off
HOLD_FRAMES, 200, frames page1 stays displayed per grant (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
clr  in  1  synchronous soft clear, active-high, same effect as reset
page0_digits  in  16  default page, 4 BCD nibbles, [15:12] = leftmost digit
page1_digits  in  16  alert page, same layout
page1_req  in  1  level request to show page1
page1_ack  out  1  one-cycle pulse when page1 is granted
lz_en  in  1  leading-zero suppression enable
seg  out  7  active-low segments, bit0=a .. bit6=g
an  out  4  active-low digit enables, an[3]=LEFT .. an[0]=RIGHT
page  out  1  page currently displayed
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset/clr values:
  - cnt=0, digit=LEFT, page=0, hold=0, armed=1, snapshot=16'h0000.
  - an=4'b1111, seg=7'h7F, page1_ack=0, frame_tick=0.
  - Async reset forces outputs immediately, without waiting for a clk edge.
- Slot counter cnt runs 0..SCAN_DIV-1. When cnt==SCAN_DIV-1, cnt wraps to 0 and digit advances LEFT->MIDLEFT->MIDRIGHT->RIGHT->LEFT.
- Frame boundary = cycle where cnt==SCAN_DIV-1 and digit==RIGHT. frame_tick is registered and asserted in the following cycle. Frame length = 4*SCAN_DIV cycles.
- Outputs an/seg are registered, 1-cycle latency from (cnt, digit):
  - cnt<BLANK_CYC: an=4'b1111, seg=7'h7F.
  - Otherwise: an = one-hot low for digit; seg = hex-to-seg of the snapshot nibble. Encoding: 0-9, A-F; 0=7'b1000000, 1=7'b1111001, 5=7'b0010010, 7=7'b1111000.
- Snapshot: the 16-bit value shown is latched only at a frame boundary, from the page selected for the next frame. Mid-frame input changes are never visible (no tearing).
- Leading-zero suppression (lz_en=1): a digit is suppressed if it and all digits to its left are 0. RIGHT is never suppressed. A suppressed digit keeps an=4'b1111 for its whole slot. lz_en is sampled per slot.
- Page arbiter FSM:
  - P0:
    - page1_req is sampled only at a frame boundary.
    - If req==1 and armed==1 at the boundary: go to P1, page=1, page1_ack pulses for one cycle (same cycle as frame_tick), hold=HOLD_FRAMES-1, armed=0, and the snapshot takes page1_digits.
  - P1:
    - Each frame boundary: if hold!=0, hold decrements and the snapshot refreshes from page1_digits.
    - If hold==0: return to P0 and the snapshot takes page0_digits.
    - A req drop during P1 does not shorten the hold.
  - Re-arm rule: armed is set at any frame boundary where page1_req==0. A continuously held request is therefore granted once only and page0 is never starved.
  - Reset or clr in any state returns to P0 and the LEFT digit. The first digit is lit after BLANK_CYC+1 cycles.
- No combinational path from inputs to outputs.

Decomposition:
- Package seg_pkg:
  - digit state enum (LEFT=2'b00, MIDLEFT=2'b01, MIDRIGHT=2'b10, RIGHT=2'b11);
  - page FSM enum (P0, P1);
  - SEG_BLANK=7'h7F;
  - AN_OFF=4'b1111.
- Sub-module hex_seg_lut: combinational 4-bit to 7-bit active-low LUT, instantiated once on the selected snapshot nibble.
- Arbiter and scan logic stay in the top module.

Test Plan:
- SCAN_DIV=8, BLANK_CYC=2, HOLD_FRAMES=3.
- page0=16'h1234, lz_en=0 -> each slot has 2 cycles an=1111, then 6 cycles with an=0111/seg=1111001, then an=1011, 1101, 1110 showing 2, 3, 4; frame_tick every 32 cycles.
- lz_en=1, page0=16'h0050 -> LEFT/MIDLEFT slots keep an=1111; MIDRIGHT shows 5 and RIGHT shows 0. page0=16'h0000 -> only RIGHT is lit, seg=1000000.
- page1=16'h0007, page1_req pulsed high mid-frame and held to the boundary -> switch at the next boundary: page1_ack is high for exactly 1 cycle, page=1 for exactly 3 frames (96 cycles), then page=0.
- page1_req held high continuously through and after the hold -> exactly one ack. Drop req for one boundary, raise again -> second ack at the next boundary.
- Change page0 from 16'h1234 to 16'h9999 in MIDLEFT of a frame -> remaining digits still show 3 and 4; 9999 appears from the next frame.
- Assert reset low mid-slot with no clk edge -> an=1111, seg=7F immediately. After release, LEFT is lit at cycle 3. Assert clr during P1 -> next cycle page=0, cnt=0, digit=LEFT.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
package seg_pkg;

    typedef enum logic [1:0] {
        LEFT     = 2'b00,
        MIDLEFT  = 2'b01,
        MIDRIGHT = 2'b10,
        RIGHT    = 2'b11
    } digit_e;

    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } page_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/seg_scan_scheduler_if.sv
// Datapath-side bundle: two BCD pages and the alert request in, pin-level scan outputs back.
interface seg_scan_scheduler_if;
    logic        clr;
    logic [15:0] page0_digits;
    logic [15:0] page1_digits;
    logic        page1_req;
    logic        page1_ack;
    logic        lz_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        page;
    logic        frame_tick;

    modport master (
        output clr, page0_digits, page1_digits, page1_req, lz_en,
        input  page1_ack, seg, an, page, frame_tick
    );

    modport slave (
        input  clr, page0_digits, page1_digits, page1_req, lz_en,
        output page1_ack, seg, an, page, frame_tick
    );
endinterface

// File: rtl/hex_seg_lut.sv
// Hex nibble to active-low seven-segment pattern, bit0=a .. bit6=g.
module hex_seg_lut (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = 7'h7F;
        case (i_nib)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
        endcase
    end
endmodule

// File: rtl/seg_scan_scheduler.sv
// Four-digit scan controller with per-slot blanking and a frame-synchronous
// page0/page1 arbiter; the shown value only changes at frame boundaries.
module seg_scan_scheduler
    import seg_pkg::*;
#(
    parameter int SCAN_DIV    = 4096,
    parameter int BLANK_CYC   = 64,
    parameter int HOLD_FRAMES = 200
) (
    input logic                 clk,
    input logic                 reset,
    seg_scan_scheduler_if.slave bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] r_cnt;
    digit_e        r_digit;
    page_e         r_state;
    logic [HW-1:0] r_hold;
    logic          r_armed;
    logic [15:0]   r_snap;
    logic          r_lz;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_ack;
    logic          r_tick;

    logic       w_slot_end;
    logic       w_frame_end;
    logic [3:0] w_nib;
    logic       w_zero_prefix;
    logic       w_lit;
    logic [6:0] w_seg;

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_digit == RIGHT);

    // Suppression looks at the current digit and everything to its left.
    always_comb begin
        w_nib         = r_snap[3:0];
        w_zero_prefix = 1'b0;
        case (r_digit)
            LEFT: begin
                w_nib         = r_snap[15:12];
                w_zero_prefix = (r_snap[15:12] == 4'h0);
            end
            MIDLEFT: begin
                w_nib         = r_snap[11:8];
                w_zero_prefix = (r_snap[15:8] == 8'h00);
            end
            MIDRIGHT: begin
                w_nib         = r_snap[7:4];
                w_zero_prefix = (r_snap[15:4] == 12'h000);
            end
            RIGHT: begin
                w_nib         = r_snap[3:0];
                w_zero_prefix = 1'b0;
            end
        endcase
        w_lit = (r_cnt >= CW'(BLANK_CYC)) && !(r_lz && w_zero_prefix);
    end

    hex_seg_lut u_lut (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_digit <= LEFT;
            r_state <= P0;
            r_hold  <= '0;
            r_armed <= 1'b1;
            r_snap  <= 16'h0000;
            r_lz    <= 1'b0;
            r_an    <= AN_OFF;
            r_seg   <= SEG_BLANK;
            r_ack   <= 1'b0;
            r_tick  <= 1'b0;
        end else if (bus.clr) begin
            r_cnt   <= '0;
            r_digit <= LEFT;
            r_state <= P0;
            r_hold  <= '0;
            r_armed <= 1'b1;
            r_snap  <= 16'h0000;
            r_lz    <= 1'b0;
            r_an    <= AN_OFF;
            r_seg   <= SEG_BLANK;
            r_ack   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end) begin
                r_digit <= digit_e'(r_digit + 2'd1);
                r_lz    <= bus.lz_en;
            end
            r_an   <= w_lit ? ~(4'b1000 >> r_digit) : AN_OFF;
            r_seg  <= w_lit ? w_seg : SEG_BLANK;
            r_tick <= w_frame_end;
            r_ack  <= 1'b0;
            if (w_frame_end) begin
                // A request that never drops is granted once, so page0 keeps getting frames.
                if (!bus.page1_req)
                    r_armed <= 1'b1;
                case (r_state)
                    P0: begin
                        if (bus.page1_req && r_armed) begin
                            r_state <= P1;
                            r_ack   <= 1'b1;
                            r_hold  <= HW'(HOLD_FRAMES - 1);
                            r_armed <= 1'b0;
                            r_snap  <= bus.page1_digits;
                        end else begin
                            r_snap  <= bus.page0_digits;
                        end
                    end
                    P1: begin
                        if (r_hold != '0) begin
                            r_hold <= r_hold - 1'b1;
                            r_snap <= bus.page1_digits;
                        end else begin
                            r_state <= P0;
                            r_snap  <= bus.page0_digits;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.page       = r_state;
    assign bus.page1_ack  = r_ack;
    assign bus.frame_tick = r_tick;
endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Scoreboarded bench: a frame-level reference model predicts every output cycle.
module tb_seg_scan_scheduler;
    localparam int SD = 8;
    localparam int BL = 2;
    localparam int HF = 3;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       page;
        logic       ack;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    seg_scan_scheduler_if bus();

    seg_scan_scheduler #(.SCAN_DIV(SD), .BLANK_CYC(BL), .HOLD_FRAMES(HF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int ack_cnt = 0;
    int tick_cnt = 0;
    int p1_cyc = 0;
    exp_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    endtask

    // Segment sets written active-high (bit0=a), inverted for the pins.
    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        logic [6:0] on;
        case (v)
            4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
            4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
            4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
            4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    // Reference model: elapsed cycles since reset decide slot and digit;
    // the page is tracked as "frames of page1 still owed".
    int         m_cyc, m_pos, m_d, m_left;
    bit         m_p1, m_armed, m_lz, m_fb, m_sup, m_lit;
    logic [15:0] m_snap;
    logic [3:0] m_nib [4];
    logic [3:0] m_one;
    exp_t       m_e;

    always @(posedge clk) begin
        if (!reset || bus.clr) begin
            m_cyc = 0; m_snap = 16'h0; m_p1 = 0; m_left = 0; m_armed = 1; m_lz = 0;
            m_e = '{an: 4'hF, seg: 7'h7F, page: 1'b0, ack: 1'b0, tick: 1'b0};
        end else begin
            m_pos = m_cyc % SD;
            m_d   = (m_cyc / SD) % 4;
            m_fb  = (m_pos == SD - 1) && (m_d == 3);
            for (int i = 0; i < 4; i++) m_nib[i] = 4'((m_snap >> (12 - 4 * i)) & 16'hF);
            m_sup = m_lz && (m_d != 3);
            for (int i = 0; i <= m_d; i++) if (m_nib[i] != 4'h0) m_sup = 0;
            m_lit = (m_pos >= BL) && !m_sup;
            m_one = 4'b0001 << (3 - m_d);
            m_e.an   = m_lit ? ~m_one : 4'hF;
            m_e.seg  = m_lit ? ref_seg(m_nib[m_d]) : 7'h7F;
            m_e.tick = m_fb;
            m_e.ack  = 1'b0;
            if (m_fb) begin
                if (m_p1) begin
                    m_left--;
                    if (m_left == 0) begin m_p1 = 0; m_snap = bus.page0_digits; end
                    else m_snap = bus.page1_digits;
                end else if (bus.page1_req && m_armed) begin
                    m_p1 = 1; m_left = HF; m_armed = 0; m_e.ack = 1'b1;
                    m_snap = bus.page1_digits;
                end else begin
                    m_snap = bus.page0_digits;
                end
                if (!bus.page1_req) m_armed = 1;
            end
            if (m_pos == SD - 1) m_lz = bus.lz_en;
            m_cyc++;
            m_e.page = m_p1;
        end
        q.push_back(m_e);
    end

    exp_t mon_e;
    always @(negedge clk) begin
        ack_cnt  += int'(bus.page1_ack);
        tick_cnt += int'(bus.frame_tick);
        p1_cyc   += int'(bus.page);
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("scan", {bus.an, bus.seg, bus.page, bus.page1_ack, bus.frame_tick}, mon_e);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            cyc(1);
            if (bus.frame_tick) hit = 1;
        end
        if (!hit) chk("tick_timeout", 0, 1);
    endtask

    task automatic wait_ack();
        bit hit = 0;
        for (int i = 0; i < 80 && !hit; i++) begin
            cyc(1);
            if (bus.page1_ack) hit = 1;
        end
        if (!hit) chk("ack_timeout", 0, 1);
    endtask

    task automatic rel_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 chk("left_blank_c2", bus.an, 4'b1111);
        @(posedge clk);
        #1 chk("left_lit_c3", bus.an, 4'b0111);
    endtask

    function automatic logic [15:0] rnd_page();
        logic [15:0] v = 16'h0;
        for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'($urandom_range(1, 15));
        return v;
    endfunction

    int a0, p0, t0;

    initial begin
        bus.clr = 0; bus.page0_digits = 16'h1234; bus.page1_digits = 16'h0007;
        bus.page1_req = 0; bus.lz_en = 0;
        #2 reset = 1'b0;
        #1;
        chk("rst_an", bus.an, 4'hF);
        chk("rst_seg", bus.seg, 7'h7F);
        chk("rst_flags", {bus.page, bus.page1_ack, bus.frame_tick}, 3'b000);
        cyc(3);
        rel_reset();

        t0 = tick_cnt;
        cyc(96);
        chk("ticks_3_frames", tick_cnt - t0, 3);

        bus.lz_en = 1; bus.page0_digits = 16'h0050;
        cyc(64);
        bus.page0_digits = 16'h0000;
        cyc(64);
        bus.lz_en = 0; bus.page0_digits = 16'h1234;
        cyc(64);

        wait_tick(); cyc(10);
        a0 = ack_cnt; p0 = p1_cyc;
        bus.page1_req = 1;
        wait_ack();
        bus.page1_req = 0;
        cyc(160);
        chk("ack_once", ack_cnt - a0, 1);
        chk("p1_len", p1_cyc - p0, 96);

        a0 = ack_cnt;
        bus.page1_req = 1;
        cyc(256);
        chk("ack_held", ack_cnt - a0, 1);
        wait_tick(); cyc(5);
        bus.page1_req = 0;
        wait_tick(); cyc(5);
        a0 = ack_cnt;
        bus.page1_req = 1;
        cyc(64);
        chk("ack_rearm", ack_cnt - a0, 1);
        bus.page1_req = 0;
        cyc(128);

        wait_tick(); cyc(10);
        bus.page0_digits = 16'h9999;
        cyc(12);
        chk("tear_an", bus.an, 4'b1101);
        chk("tear_seg", bus.seg, 7'b0110000);
        wait_tick(); cyc(5);
        chk("new_frame_an", bus.an, 4'b0111);
        chk("new_frame_seg", bus.seg, 7'b0010000);

        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_an", bus.an, 4'hF);
        chk("async_seg", bus.seg, 7'h7F);
        cyc(2);
        rel_reset();

        cyc(64);
        bus.page1_req = 1;
        wait_ack();
        bus.page1_req = 0;
        cyc(20);
        chk("pre_clr_page", bus.page, 1'b1);
        bus.clr = 1;
        cyc(1);
        chk("clr_page", bus.page, 1'b0);
        chk("clr_an", bus.an, 4'hF);
        bus.clr = 0;
        cyc(40);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) bus.page0_digits = rnd_page();
            if ($urandom_range(0, 59) == 0) bus.page1_digits = rnd_page();
            if ($urandom_range(0, 29) == 0) bus.page1_req = ~bus.page1_req;
            if ($urandom_range(0, 149) == 0) bus.lz_en = ~bus.lz_en;
            bus.clr = ($urandom_range(0, 699) == 0);
            cyc(1);
        end
        bus.clr = 0;
        cyc(4);
        @(negedge clk);
        #1 chk("queue_drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
